// File: rtl/life_step_scheduler_pkg.sv
// ============================================================================
// Module   : life_sched_pkg
// Purpose  : Shared state encoding and default widths for the generation scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package life_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam int DEF_PERIOD_W     = 8;
    localparam int DEF_GEN_W        = 16;
    localparam int TICKS_PER_SECOND = 12_000_000;

endpackage

`default_nettype wire

// File: rtl/life_step_scheduler_if.sv
// ============================================================================
// Module   : life_step_scheduler_if
// Purpose  : Control/handshake bundle between tick timer, scheduler and update engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface life_step_scheduler_if
    import life_sched_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int GEN_W    = DEF_GEN_W
);
    logic                tick;
    logic                run_en;
    logic                step_req;
    logic [PERIOD_W-1:0] period;
    logic                update_done;
    logic                ovr_clr;
    logic                update_start;
    logic                busy;
    logic                running;
    logic [GEN_W-1:0]    generation;
    logic                overrun;

    modport slave (
        input  tick, run_en, step_req, period, update_done, ovr_clr,
        output update_start, busy, running, generation, overrun
    );

    modport master (
        output tick, run_en, step_req, period, update_done, ovr_clr,
        input  update_start, busy, running, generation, overrun
    );
endinterface

`default_nettype wire

// File: rtl/life_step_scheduler.sv
// ============================================================================
// Module   : life_step_scheduler
// Purpose  : Issues board-update starts every PERIOD ticks, with pause/step and overrun flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module life_step_scheduler
    import life_sched_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int GEN_W    = DEF_GEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    life_step_scheduler_if.slave   bus
);

    localparam logic [PERIOD_W:0] C_ONE_W = {{PERIOD_W{1'b0}}, 1'b1};
    localparam logic [GEN_W-1:0]  C_ONE_G = {{(GEN_W-1){1'b0}}, 1'b1};

    state_t              r_state, w_state_nxt;
    logic                r_ret_wait, w_ret_nxt;
    logic [PERIOD_W-1:0] r_tick_cnt, w_cnt_nxt;
    logic                r_start, w_start_nxt;
    logic                r_busy;
    logic                r_running;
    logic                r_overrun;
    logic [GEN_W-1:0]    r_gen;
    logic                w_gen_inc;
    logic                w_ovr_set;
    logic [PERIOD_W:0]   w_eff;
    logic [PERIOD_W:0]   w_cnt_inc;
    logic                w_hit;

    // One extra bit keeps the compare exact at the maximum period.
    assign w_eff     = (bus.period == '0) ? C_ONE_W : {1'b0, bus.period};
    assign w_cnt_inc = {1'b0, r_tick_cnt} + C_ONE_W;
    assign w_hit     = bus.tick && (w_cnt_inc >= w_eff);

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret_wait;
        w_cnt_nxt   = r_tick_cnt;
        w_start_nxt = 1'b0;
        w_gen_inc   = 1'b0;
        w_ovr_set   = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (bus.step_req) begin
                    w_start_nxt = 1'b1;
                    w_state_nxt = UPDATE;
                    w_ret_nxt   = bus.run_en;
                end else if (bus.run_en) begin
                    w_state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (!bus.run_en) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_hit) begin
                    w_cnt_nxt   = '0;
                    w_start_nxt = 1'b1;
                    w_state_nxt = UPDATE;
                    w_ret_nxt   = 1'b1;
                end else if (bus.tick) begin
                    w_cnt_nxt = w_cnt_inc[PERIOD_W-1:0];
                end
            end

            UPDATE: begin
                // Free-run cadence keeps counting; a boundary hit here is a dropped generation.
                if (r_ret_wait && w_hit) begin
                    w_ovr_set = 1'b1;
                    w_cnt_nxt = '0;
                end else if (r_ret_wait && bus.tick) begin
                    w_cnt_nxt = w_cnt_inc[PERIOD_W-1:0];
                end
                if (bus.update_done) begin
                    w_gen_inc = 1'b1;
                    if (r_ret_wait && bus.run_en) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ret_wait <= 1'b0;
            r_tick_cnt <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_running  <= 1'b0;
            r_overrun  <= 1'b0;
            r_gen      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ret_wait <= w_ret_nxt;
            r_tick_cnt <= w_cnt_nxt;
            r_start    <= w_start_nxt;
            r_busy     <= (w_state_nxt == UPDATE);
            r_running  <= (w_state_nxt == WAIT) || ((w_state_nxt == UPDATE) && w_ret_nxt);
            if (w_gen_inc) begin
                r_gen <= r_gen + C_ONE_G;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (bus.ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.update_start = r_start;
    assign bus.busy         = r_busy;
    assign bus.running      = r_running;
    assign bus.generation   = r_gen;
    assign bus.overrun      = r_overrun;

endmodule

`default_nettype wire
